bfm_core: RTL and testbench
===========================

Name: bfm_core

Overview:
- Pipelined two-operand arithmetic/logic unit, the DUT of the TLM data-streaming bench.
- The bench drives a new operand pair (A_s, B_s) every clock from a DPI-generated payload.
- The block registers the pair, applies a compile-time-selected operation, and presents the result on res_o after a fixed latency.
- There is no handshake: every clock edge is a valid transfer.

Parameters:
- WIDTH, 8, bit width of A_s, B_s and res_o.
- OP, 0, operation select: 0 ADD, 1 SUB (A-B), 2 MUL (low WIDTH bits), 3 AND, 4 OR, 5 XOR. Any other value behaves as ADD.
- PIPE_STAGES, 1, register stages from input sample to res_o. Legal range 1..4; a value outside the range is an elaboration error.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- A_s  input  WIDTH  operand A, sampled every rising edge.
- B_s  input  WIDTH  operand B, sampled every rising edge.
- res_o  output  WIDTH  registered result.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - reset_i=0 immediately clears all pipeline registers and res_o to 0, regardless of clock.
  - While held low, res_o stays 0.
- Reset release: the first operands are sampled at the first rising edge with reset_i=1. There are no extra dead cycles.
- Reset mid-stream: all in-flight results are discarded. res_o shows 0 until the first post-reset sample has propagated.
- Latency:
  - Operands sampled at rising edge t appear on res_o immediately after edge t+PIPE_STAGES-1.
  - PIPE_STAGES=1: res_o updates on the same edge that samples A_s/B_s.
  - Throughput is one result per clock; there are no bubbles and no stalls.
- Structure:
  - Stage 1 computes the operation combinationally from A_s/B_s and registers it.
  - Later stages are pure delay registers.
  - res_o is driven directly from the last stage, with no combinational path from inputs to res_o.
- Arithmetic, all unsigned:
  - ADD: (A+B) mod 2^WIDTH. The carry is dropped.
  - SUB: (A-B) mod 2^WIDTH. A borrow wraps.
  - MUL: the full 2*WIDTH-bit product is formed internally; the low WIDTH bits are output.
  - AND/OR/XOR: bitwise.
- Unknown or X inputs must not corrupt the reset value. Reset has priority over any clock edge.
- There is no internal state beyond the pipeline, so results depend only on the operands PIPE_STAGES-1 edges earlier.

Optional Feature:
- Macro: BFM_CORE_SAT_EN.
- Defined: arithmetic ops saturate instead of wrapping.
  - ADD clamps to 2^WIDTH-1 on carry.
  - SUB clamps to 0 when B>A.
  - MUL clamps to 2^WIDTH-1 when the product exceeds 2^WIDTH-1.
  - Logic ops are unchanged.
  - Latency is unchanged.
- Not defined: wrap-around behaviour as in Behaviour. No saturation logic is present.

Test Plan:
- Reset: hold reset_i=0 for 5 cycles with A_s=0x12, B_s=0x34 -> res_o=0 throughout. Assert reset_i=0 asynchronously between edges -> res_o drops to 0 before the next edge.
- ADD stream, OP=0, PIPE_STAGES=1: A/B = (0x01,0x02), (0x10,0x20), (0xFF,0x01) on consecutive edges -> res_o = 0x03, 0x30, 0x00 on the same edges.
  - With BFM_CORE_SAT_EN defined, the last result is 0xFF.
- SUB and MUL wrap:
  - OP=1: A=0x05, B=0x07 -> 0xFE, or 0x00 with BFM_CORE_SAT_EN.
  - OP=2: A=0x10, B=0x11 -> 0x10, or 0xFF with BFM_CORE_SAT_EN.
- Latency, PIPE_STAGES=3, OP=5: A=0xAA, B=0x55 sampled at edge t, other pairs before and after -> 0xFF appears on res_o exactly after edge t+2, neighbours in order, with no gaps.
- Reset mid-stream, PIPE_STAGES=3: pulse reset_i low for 1 cycle while 2 results are in flight -> both are lost. res_o=0 until the first post-reset pair emerges 2 edges after its sample.
- Burst of 100 random pairs, repeated 5 times, OP=0 -> every res_o equals (A+B) mod 256 of the pair PIPE_STAGES-1 edges earlier, compared against a scoreboard.

Source files
------------

// File: rtl/bfm_core_if.sv
// rtl/bfm_core_if.sv - operand/result bus of the bfm_core pipelined ALU
interface bfm_core_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A_s;
  logic [WIDTH-1:0] B_s;
  logic [WIDTH-1:0] res_o;

  modport master (output A_s, output B_s, input  res_o);
  modport slave  (input  A_s, input  B_s, output res_o);
endinterface

// File: rtl/bfm_core.sv
// rtl/bfm_core.sv - pipelined two-operand ALU, result after PIPE_STAGES registers
// Optional saturating arithmetic: define BFM_CORE_SAT_EN.
module bfm_core #(
  parameter int WIDTH       = 8,
  parameter int OP          = 0,
  parameter int PIPE_STAGES = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  bfm_core_if.slave  bus
);

  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("bfm_core: PIPE_STAGES must be in 1..4");
  end

  logic [WIDTH-1:0] op_d;
  logic [WIDTH-1:0] stage_q [PIPE_STAGES];

`ifdef BFM_CORE_SAT_EN
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [2*WIDTH-1:0] prod_w;

  always_comb begin
    sum_w  = {1'b0, bus.A_s} + {1'b0, bus.B_s};
    diff_w = {1'b0, bus.A_s} - {1'b0, bus.B_s};
    prod_w = {{WIDTH{1'b0}}, bus.A_s} * {{WIDTH{1'b0}}, bus.B_s};
    op_d   = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
    case (OP)
      1:       op_d = diff_w[WIDTH] ? '0 : diff_w[WIDTH-1:0];
      2:       op_d = (|prod_w[2*WIDTH-1:WIDTH]) ? '1 : prod_w[WIDTH-1:0];
      3:       op_d = bus.A_s & bus.B_s;
      4:       op_d = bus.A_s | bus.B_s;
      5:       op_d = bus.A_s ^ bus.B_s;
      default: ;
    endcase
  end
`else
  // Operands and result share WIDTH, so each expression wraps mod 2^WIDTH.
  always_comb begin
    op_d = bus.A_s + bus.B_s;
    case (OP)
      1:       op_d = bus.A_s - bus.B_s;
      2:       op_d = bus.A_s * bus.B_s;
      3:       op_d = bus.A_s & bus.B_s;
      4:       op_d = bus.A_s | bus.B_s;
      5:       op_d = bus.A_s ^ bus.B_s;
      default: ;
    endcase
  end
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < PIPE_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= op_d;
      for (int i = 1; i < PIPE_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign bus.res_o = stage_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_bfm_core.sv
// tb/tb_bfm_core.sv - self-checking bench for bfm_core across several OP/PIPE_STAGES builds
module tb_bfm_core;

  localparam int NDUT = 5;

`ifdef BFM_CORE_SAT_EN
  localparam logic [7:0] EXP_ADD_OVF = 8'hFF;
  localparam logic [7:0] EXP_SUB     = 8'h00;
  localparam logic [7:0] EXP_MUL     = 8'hFF;
  localparam bit         SAT         = 1'b1;
`else
  localparam logic [7:0] EXP_ADD_OVF = 8'h00;
  localparam logic [7:0] EXP_SUB     = 8'hFE;
  localparam logic [7:0] EXP_MUL     = 8'h10;
  localparam bit         SAT         = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic [7:0] a = 8'h12;
  logic [7:0] b = 8'h34;
  bit         run = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  bfm_core_if #(.WIDTH(8)) if_add1 ();
  bfm_core_if #(.WIDTH(8)) if_sub1 ();
  bfm_core_if #(.WIDTH(8)) if_mul1 ();
  bfm_core_if #(.WIDTH(8)) if_xor3 ();
  bfm_core_if #(.WIDTH(8)) if_add3 ();

  assign if_add1.A_s = a; assign if_add1.B_s = b;
  assign if_sub1.A_s = a; assign if_sub1.B_s = b;
  assign if_mul1.A_s = a; assign if_mul1.B_s = b;
  assign if_xor3.A_s = a; assign if_xor3.B_s = b;
  assign if_add3.A_s = a; assign if_add3.B_s = b;

  bfm_core #(.WIDTH(8), .OP(0), .PIPE_STAGES(1)) u_add1 (.clk_i(clk), .reset_i(reset_i), .bus(if_add1));
  bfm_core #(.WIDTH(8), .OP(1), .PIPE_STAGES(1)) u_sub1 (.clk_i(clk), .reset_i(reset_i), .bus(if_sub1));
  bfm_core #(.WIDTH(8), .OP(2), .PIPE_STAGES(1)) u_mul1 (.clk_i(clk), .reset_i(reset_i), .bus(if_mul1));
  bfm_core #(.WIDTH(8), .OP(5), .PIPE_STAGES(3)) u_xor3 (.clk_i(clk), .reset_i(reset_i), .bus(if_xor3));
  bfm_core #(.WIDTH(8), .OP(0), .PIPE_STAGES(3)) u_add3 (.clk_i(clk), .reset_i(reset_i), .bus(if_add3));

  logic [7:0] res [NDUT];
  assign res[0] = if_add1.res_o;
  assign res[1] = if_sub1.res_o;
  assign res[2] = if_mul1.res_o;
  assign res[3] = if_xor3.res_o;
  assign res[4] = if_add3.res_o;

  int    cfg_op [NDUT] = '{0, 1, 2, 5, 0};
  int    cfg_p  [NDUT] = '{1, 1, 1, 3, 3};
  string cfg_nm [NDUT] = '{"add1", "sub1", "mul1", "xor3", "add3"};

  // Model: history of operand pairs accepted since the last reset, newest last.
  logic [15:0] hist [$];

  function automatic logic [7:0] alu(int op, logic [7:0] x, logic [7:0] y);
    int r;
    case (op)
      1:       begin r = int'(x) - int'(y); if (SAT && r < 0) r = 0; end
      2:       begin r = int'(x) * int'(y); if (SAT && r > 255) r = 255; end
      3:       r = int'(x & y);
      4:       r = int'(x | y);
      5:       r = int'(x ^ y);
      default: begin r = int'(x) + int'(y); if (SAT && r > 255) r = 255; end
    endcase
    return 8'(r);
  endfunction

  function automatic logic [7:0] model(int op, int p);
    logic [15:0] pr;
    if (hist.size() < p) return 8'h00;
    pr = hist[hist.size() - p];
    return alu(op, pr[15:8], pr[7:0]);
  endfunction

  always @(posedge clk or negedge reset_i) begin
    if (!reset_i) hist.delete();
    else begin
      hist.push_back({a, b});
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < NDUT; i++) chk({"model_", cfg_nm[i]}, res[i], model(cfg_op[i], cfg_p[i]));
    end
  end

  task automatic step(logic [7:0] av, logic [7:0] bv);
    a = av;
    b = bv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold_add1", res[0], 8'h00);
      chk("reset_hold_xor3", res[3], 8'h00);
    end
    reset_i = 1'b1;

    step(8'h01, 8'h02); chk("add_01_02", res[0], 8'h03);
    step(8'h10, 8'h20); chk("add_10_20", res[0], 8'h30);
    step(8'hFF, 8'h01); chk("add_ff_01", res[0], EXP_ADD_OVF);
    step(8'h05, 8'h07); chk("sub_05_07", res[1], EXP_SUB);
    step(8'h10, 8'h11); chk("mul_10_11", res[2], EXP_MUL);

    step(8'h0F, 8'h01);
    step(8'hAA, 8'h55);
    step(8'h33, 8'h0F); chk("lat_t+1", res[3], 8'h0E);
    step(8'h00, 8'h00); chk("lat_t+2", res[3], 8'hFF);
    step(8'h00, 8'h00); chk("lat_t+3", res[3], 8'h3C);

    #2 reset_i = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) chk({"async_rst_", cfg_nm[i]}, res[i], 8'h00);
    @(posedge clk);
    #1 reset_i = 1'b1;

    step(8'h01, 8'h01);
    step(8'h02, 8'h02);
    #1 reset_i = 1'b0;
    @(posedge clk);
    #1 reset_i = 1'b1;
    step(8'h05, 8'h06); chk("mid_rst_e0", res[4], 8'h00);
    step(8'h07, 8'h07); chk("mid_rst_e1", res[4], 8'h00);
    step(8'h00, 8'h00); chk("mid_rst_e2", res[4], 8'h0B);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 100; i++) step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    @(negedge clk);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
